branch_stack: RTL and testbench

- Checkpoint stack for in-flight conditional branches; sits directly downstream of the branch functional unit.
- At dispatch it allocates a one-hot branch ID and snapshots the free-list head and ROB tail.
- At resolution it consumes the branch unit's task (NOTHING/CLEAR/SQUASH), resolving branch ID and target.
- It broadcasts either a mask-bit clear or a full recovery: restore pointers, squash mask, redirect PC.

---
 rtl/branch_stack_pkg.sv | 26 ++
 rtl/branch_stack_lowest_free_sel.sv | 22 ++
 rtl/branch_stack.sv | 143 ++++++++++++++
 tb/tb_branch_stack.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_stack_pkg.sv
// Shared types for the branch checkpoint stack: resolution task encoding,
// address/mask types and the checkpoint entry layout.
package branch_stack_pkg;

    localparam int unsigned BS_DEPTH     = 4;
    localparam int unsigned BS_FL_IDX_W  = 5;
    localparam int unsigned BS_ROB_IDX_W = 5;
    localparam int unsigned ADDR_W       = 32;

    typedef logic [ADDR_W-1:0]   ADDR;
    typedef logic [BS_DEPTH-1:0] B_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic                    valid;
        B_MASK                   b_mask;
        logic [BS_FL_IDX_W-1:0]  fl_head;
        logic [BS_ROB_IDX_W-1:0] rob_tail;
    } BSTACK_ENTRY;

endpackage

// File: rtl/branch_stack_lowest_free_sel.sv
// Priority encoder: one-hot select of the lowest set bit of the free vector.
module branch_stack_lowest_free_sel #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] free,
    output logic [N-1:0] sel
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (free[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// Checkpoint stack for in-flight branches: one-hot ID allocation, CLEAR/SQUASH
// resolution and recovery broadcast. Optional counters: BRANCH_STACK_STATS_EN.
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter int unsigned DEPTH     = BS_DEPTH,
    parameter int unsigned FL_IDX_W  = BS_FL_IDX_W,
    parameter int unsigned ROB_IDX_W = BS_ROB_IDX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [FL_IDX_W-1:0]  alloc_fl_head,
    input  logic [ROB_IDX_W-1:0] alloc_rob_tail,
    output logic [DEPTH-1:0]     alloc_b_id,
    output logic [DEPTH-1:0]     alloc_b_mask,
    output logic                 full,
    input  BR_TASK               br_task,
    input  logic [DEPTH-1:0]     res_b_id,
    input  ADDR                  res_target,
    output logic [DEPTH-1:0]     clear_b_id,
    output logic                 rec_valid,
    output logic [FL_IDX_W-1:0]  rec_fl_head,
    output logic [ROB_IDX_W-1:0] rec_rob_tail,
    output ADDR                  rec_pc,
    output logic [DEPTH-1:0]     squash_mask
`ifdef BRANCH_STACK_STATS_EN
    ,
    output logic [31:0]          stat_clears,
    output logic [31:0]          stat_squashes
`endif
);

    // Local entry type so widths follow this instance's parameters.
    typedef struct packed {
        logic                 valid;
        logic [DEPTH-1:0]     b_mask;
        logic [FL_IDX_W-1:0]  fl_head;
        logic [ROB_IDX_W-1:0] rob_tail;
    } entry_t;

    entry_t               entries [DEPTH];
    logic [DEPTH-1:0]     live;
    logic [DEPTH-1:0]     free_sel;
    logic [DEPTH-1:0]     squash_set;
    logic [FL_IDX_W-1:0]  res_fl_head;
    logic [ROB_IDX_W-1:0] res_rob_tail;
    logic                 res_legal;
    logic                 do_clear;
    logic                 do_squash;
    logic                 alloc_ok;

    always_comb begin
        live         = '0;
        squash_set   = res_b_id;
        res_fl_head  = '0;
        res_rob_tail = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live[i] = entries[i].valid;
            if (entries[i].valid && (|(entries[i].b_mask & res_b_id)))
                squash_set[i] = 1'b1;
            if (res_b_id[i]) begin
                res_fl_head  = res_fl_head | entries[i].fl_head;
                res_rob_tail = res_rob_tail | entries[i].rob_tail;
            end
        end
    end

    branch_stack_lowest_free_sel #(
        .N(DEPTH)
    ) u_free_sel (
        .free(~live),
        .sel (free_sel)
    );

    // Malformed or stale resolutions degrade to NOTHING.
    always_comb begin
        res_legal    = $onehot(res_b_id) && (|(res_b_id & live));
        do_clear     = (br_task == CLEAR) && res_legal;
        do_squash    = (br_task == SQUASH) && res_legal;
        full         = &live;
        alloc_ok     = alloc_en && !full && (br_task != SQUASH);
        alloc_b_id   = alloc_ok ? free_sel : '0;
        alloc_b_mask = do_clear ? (live & ~res_b_id) : live;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entries[i] <= '0;
            clear_b_id   <= '0;
            rec_valid    <= 1'b0;
            rec_fl_head  <= '0;
            rec_rob_tail <= '0;
            rec_pc       <= '0;
            squash_mask  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_b_id[i]) begin
                    entries[i] <= '{valid: 1'b1, b_mask: alloc_b_mask,
                                    fl_head: alloc_fl_head, rob_tail: alloc_rob_tail};
                end else if (do_clear) begin
                    entries[i].b_mask <= entries[i].b_mask & ~res_b_id;
                    if (res_b_id[i])
                        entries[i].valid <= 1'b0;
                end else if (do_squash && squash_set[i]) begin
                    entries[i].valid <= 1'b0;
                end
            end
            clear_b_id  <= do_clear ? res_b_id : '0;
            rec_valid   <= do_squash;
            squash_mask <= do_squash ? squash_set : '0;
            if (do_squash) begin
                rec_fl_head  <= res_fl_head;
                rec_rob_tail <= res_rob_tail;
                rec_pc       <= res_target;
            end
        end
    end

`ifdef BRANCH_STACK_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_clears   <= '0;
            stat_squashes <= '0;
        end else begin
            if (do_clear)
                stat_clears <= stat_clears + 32'd1;
            if (do_squash)
                stat_squashes <= stat_squashes + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && br_task != NOTHING)
            assert (res_legal)
            else $warning("branch_stack: illegal resolution ignored (res_b_id=%b)", res_b_id);
    end
`endif

endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack: vector table plus scoreboard of
// registered resolution outputs, and hand sequences for reset/stats.
module tb_branch_stack;
    import branch_stack_pkg::*;

    typedef struct {
        logic       a_en;
        logic [4:0] fl;
        logic [4:0] rob;
        BR_TASK     tsk;
        logic [3:0] rid;
        ADDR        tgt;
        logic [3:0] e_id;
        logic [3:0] e_mask;
        logic       e_full;
        logic [3:0] e_clr;
        logic       e_rv;
        logic [3:0] e_sq;
        logic [4:0] e_fl;
        logic [4:0] e_rob;
        ADDR        e_pc;
    } vec_t;

    typedef struct {
        logic [3:0] clr;
        logic       rv;
        logic [3:0] sq;
        logic [4:0] fl;
        logic [4:0] rob;
        ADDR        pc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_en = 1'b0;
    logic [4:0] alloc_fl_head = '0;
    logic [4:0] alloc_rob_tail = '0;
    logic [3:0] alloc_b_id;
    logic [3:0] alloc_b_mask;
    logic       full;
    BR_TASK     br_task = NOTHING;
    logic [3:0] res_b_id = '0;
    ADDR        res_target = '0;
    logic [3:0] clear_b_id;
    logic       rec_valid;
    logic [4:0] rec_fl_head;
    logic [4:0] rec_rob_tail;
    ADDR        rec_pc;
    logic [3:0] squash_mask;
`ifdef BRANCH_STACK_STATS_EN
    logic [31:0] stat_clears;
    logic [31:0] stat_squashes;
`endif

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];
    vec_t tbl[17];

    branch_stack #(
        .DEPTH(4),
        .FL_IDX_W(5),
        .ROB_IDX_W(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_en      (alloc_en),
        .alloc_fl_head (alloc_fl_head),
        .alloc_rob_tail(alloc_rob_tail),
        .alloc_b_id    (alloc_b_id),
        .alloc_b_mask  (alloc_b_mask),
        .full          (full),
        .br_task       (br_task),
        .res_b_id      (res_b_id),
        .res_target    (res_target),
        .clear_b_id    (clear_b_id),
        .rec_valid     (rec_valid),
        .rec_fl_head   (rec_fl_head),
        .rec_rob_tail  (rec_rob_tail),
        .rec_pc        (rec_pc),
        .squash_mask   (squash_mask)
`ifdef BRANCH_STACK_STATS_EN
        ,
        .stat_clears   (stat_clears),
        .stat_squashes (stat_squashes)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a_en, input int fl, input int rob, input BR_TASK tsk,
                                input logic [3:0] rid, input ADDR tgt, input logic [3:0] e_id,
                                input logic [3:0] e_mask, input logic e_full, input logic [3:0] e_clr,
                                input logic e_rv, input logic [3:0] e_sq, input int e_fl,
                                input int e_rob, input ADDR e_pc);
        vec_t v;
        v.a_en = a_en; v.fl = 5'(fl); v.rob = 5'(rob); v.tsk = tsk; v.rid = rid; v.tgt = tgt;
        v.e_id = e_id; v.e_mask = e_mask; v.e_full = e_full; v.e_clr = e_clr; v.e_rv = e_rv;
        v.e_sq = e_sq; v.e_fl = 5'(e_fl); v.e_rob = 5'(e_rob); v.e_pc = e_pc;
        return v;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        alloc_en       = v.a_en;
        alloc_fl_head  = v.fl;
        alloc_rob_tail = v.rob;
        br_task        = v.tsk;
        res_b_id       = v.rid;
        res_target     = v.tgt;
        #1;
        check({tag, ".alloc_b_id"}, 32'(alloc_b_id), 32'(v.e_id));
        check({tag, ".alloc_b_mask"}, 32'(alloc_b_mask), 32'(v.e_mask));
        check({tag, ".full"}, 32'(full), 32'(v.e_full));
        e.clr = v.e_clr; e.rv = v.e_rv; e.sq = v.e_sq; e.fl = v.e_fl; e.rob = v.e_rob; e.pc = v.e_pc;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        check({tag, ".clear_b_id"}, 32'(clear_b_id), 32'(got.clr));
        check({tag, ".rec_valid"}, 32'(rec_valid), 32'(got.rv));
        check({tag, ".squash_mask"}, 32'(squash_mask), 32'(got.sq));
        check({tag, ".rec_fl_head"}, 32'(rec_fl_head), 32'(got.fl));
        check({tag, ".rec_rob_tail"}, 32'(rec_rob_tail), 32'(got.rob));
        check({tag, ".rec_pc"}, rec_pc, got.pc);
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".full"}, 32'(full), 32'd0);
        check({tag, ".alloc_b_mask"}, 32'(alloc_b_mask), 32'd0);
        check({tag, ".clear_b_id"}, 32'(clear_b_id), 32'd0);
        check({tag, ".rec_valid"}, 32'(rec_valid), 32'd0);
        check({tag, ".squash_mask"}, 32'(squash_mask), 32'd0);
        check({tag, ".rec_fl_head"}, 32'(rec_fl_head), 32'd0);
        check({tag, ".rec_rob_tail"}, 32'(rec_rob_tail), 32'd0);
        check({tag, ".rec_pc"}, rec_pc, 32'd0);
    endtask

    initial begin
        //             en fl rob task    rid      tgt        id       mask     f  clr      rv sq       fl rob pc
        tbl[0]  = mk(1, 1, 2,  NOTHING, 4'b0000, 0,        4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0,  0);
        tbl[1]  = mk(1, 3, 4,  NOTHING, 4'b0000, 0,        4'b0010, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 0,  0);
        tbl[2]  = mk(1, 7, 12, NOTHING, 4'b0000, 0,        4'b0100, 4'b0011, 0, 4'b0000, 0, 4'b0000, 0, 0,  0);
        tbl[3]  = mk(1, 9, 20, NOTHING, 4'b0000, 0,        4'b1000, 4'b0111, 0, 4'b0000, 0, 4'b0000, 0, 0,  0);
        tbl[4]  = mk(1, 1, 1,  NOTHING, 4'b0000, 0,        4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0,  0);
        tbl[5]  = mk(1, 0, 0,  CLEAR,   4'b0010, 0,        4'b0000, 4'b1101, 1, 4'b0010, 0, 4'b0000, 0, 0,  0);
        tbl[6]  = mk(1, 11, 13, NOTHING, 4'b0000, 0,       4'b0010, 4'b1101, 0, 4'b0000, 0, 4'b0000, 0, 0,  0);
        tbl[7]  = mk(1, 3, 3,  SQUASH,  4'b0100, 32'h1040, 4'b0000, 4'b1111, 1, 4'b0000, 1, 4'b1110, 7, 12, 32'h1040);
        tbl[8]  = mk(0, 0, 0,  NOTHING, 4'b0000, 0,        4'b0000, 4'b0001, 0, 4'b0000, 0, 4'b0000, 7, 12, 32'h1040);
        tbl[9]  = mk(1, 5, 5,  NOTHING, 4'b0000, 0,        4'b0010, 4'b0001, 0, 4'b0000, 0, 4'b0000, 7, 12, 32'h1040);
        tbl[10] = mk(1, 2, 2,  SQUASH,  4'b0010, 32'h2000, 4'b0000, 4'b0011, 0, 4'b0000, 1, 4'b0010, 5, 5,  32'h2000);
        tbl[11] = mk(0, 0, 0,  NOTHING, 4'b0000, 0,        4'b0000, 4'b0001, 0, 4'b0000, 0, 4'b0000, 5, 5,  32'h2000);
        tbl[12] = mk(1, 6, 6,  NOTHING, 4'b0000, 0,        4'b0010, 4'b0001, 0, 4'b0000, 0, 4'b0000, 5, 5,  32'h2000);
        tbl[13] = mk(1, 8, 9,  CLEAR,   4'b0001, 0,        4'b0100, 4'b0010, 0, 4'b0001, 0, 4'b0000, 5, 5,  32'h2000);
        tbl[14] = mk(1, 10, 10, NOTHING, 4'b0000, 0,       4'b0001, 4'b0110, 0, 4'b0000, 0, 4'b0000, 5, 5,  32'h2000);
        tbl[15] = mk(0, 0, 0,  SQUASH,  4'b0010, 32'h3000, 4'b0000, 4'b0111, 0, 4'b0000, 1, 4'b0111, 6, 6,  32'h3000);
        tbl[16] = mk(0, 0, 0,  NOTHING, 4'b0000, 0,        4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 6, 6,  32'h3000);

        // Power-on reset
        @(negedge clock);
        #1;
        check_all_zero("por");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 17; k++)
            apply(tbl[k], $sformatf("v%0d", k));

        // Reset asserted mid-operation with three live entries
        apply(mk(1, 1, 1, NOTHING, 4'b0000, 0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b0000, 6, 6, 32'h3000), "rst_a0");
        apply(mk(1, 2, 2, NOTHING, 4'b0000, 0, 4'b0010, 4'b0001, 0, 4'b0000, 0, 4'b0000, 6, 6, 32'h3000), "rst_a1");
        apply(mk(1, 3, 3, NOTHING, 4'b0000, 0, 4'b0100, 4'b0011, 0, 4'b0000, 0, 4'b0000, 6, 6, 32'h3000), "rst_a2");
        alloc_en = 1'b0;
        br_task  = NOTHING;
        res_b_id = '0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst.alloc_b_id", 32'(alloc_b_id), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        apply(mk(1, 2, 3, NOTHING, 4'b0000, 0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0, 0), "post_rst");

`ifdef BRANCH_STACK_STATS_EN
        apply(mk(1, 1, 1, NOTHING, 4'b0000, 0, 4'b0010, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 0, 0), "st_a1");
        apply(mk(1, 4, 4, NOTHING, 4'b0000, 0, 4'b0100, 4'b0011, 0, 4'b0000, 0, 4'b0000, 0, 0, 0), "st_a2");
        apply(mk(0, 0, 0, CLEAR,   4'b0001, 0, 4'b0000, 4'b0110, 0, 4'b0001, 0, 4'b0000, 0, 0, 0), "st_c1");
        apply(mk(0, 0, 0, CLEAR,   4'b0010, 0, 4'b0000, 4'b0100, 0, 4'b0010, 0, 4'b0000, 0, 0, 0), "st_c2");
        apply(mk(0, 0, 0, CLEAR,   4'b0011, 0, 4'b0000, 4'b0100, 0, 4'b0000, 0, 4'b0000, 0, 0, 0), "st_bad");
        apply(mk(0, 0, 0, SQUASH,  4'b0100, 32'h44, 4'b0000, 4'b0100, 0, 4'b0000, 1, 4'b0100, 4, 4, 32'h44), "st_sq");
        check("stat_clears", stat_clears, 32'd2);
        check("stat_squashes", stat_squashes, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
